// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_feeder_if                                             |
// | Purpose  : Bundles the byte-queue write port, the transmitter handshake  |
// |            and the status flags of uart_tx_feeder.                       |
// | Ports    : slave  - feeder view (drives status, tx_start, tx_data)       |
// |            master - system/transmitter view (drives writes, enable,      |
// |                     tx_busy, tx_done)                                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              enable;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              sending;
  logic              timeout;

  modport slave (
    input  wr_en, wr_data, enable, tx_busy, tx_done,
    output full, empty, count, overflow, tx_start, tx_data, sending, timeout
  );

  modport master (
    output wr_en, wr_data, enable, tx_busy, tx_done,
    input  full, empty, count, overflow, tx_start, tx_data, sending, timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_feeder                                                |
// | Purpose  : Byte FIFO plus start/done handshake sequencer in front of an  |
// |            8-bit UART transmitter, with a watchdog that abandons a byte  |
// |            if the transmitter never reports done.                        |
// | Ports    : clk   - baud-rate clock (posedge)                             |
// |            rst_n - asynchronous active-low reset                         |
// |            bus   - uart_tx_feeder_if.slave: wr_en/wr_data in,            |
// |                    full/empty/count/overflow out, enable in,             |
// |                    tx_start/tx_data out, tx_busy/tx_done in,             |
// |                    sending/timeout out                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_feeder #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_feeder_if.slave   bus
);
  localparam int                c_DEPTH    = 2 ** ADDR_W;
  localparam int                c_WD_W     = $clog2(TIMEOUT);
  localparam logic [ADDR_W:0]   c_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [c_WD_W-1:0] c_WD_LAST  = c_WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_mem [c_DEPTH];
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_count;
  logic [c_WD_W-1:0]   r_wd;
  logic [c_WD_W-1:0]   w_wd_nxt;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic                r_sending;
  logic                r_timeout;
  logic                r_overflow;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_tx_start_nxt;
  logic                w_timeout_nxt;
  logic                w_overflow_nxt;
  logic                w_unused_busy;

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);

  // tx_busy carries no control meaning here: done is trusted whenever the
  // sequencer is waiting for it.
  assign w_unused_busy = bus.tx_busy;

  // Next-state / launch decode
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_wd_nxt       = r_wd;
    case (r_state)
      S_IDLE: begin
        if (bus.enable && !w_empty) begin
          w_pop          = 1'b1;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = S_START;
        end
      end
      S_START: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_wd_nxt = r_wd + 1'b1;
        if (bus.tx_done) begin
          w_state_nxt = S_IDLE;
        end else if (r_wd == c_WD_LAST) begin
          // Byte is abandoned, not re-queued.
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign w_push         = bus.wr_en && (!w_full || w_pop);
  assign w_overflow_nxt = bus.wr_en && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wd       <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_sending  <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wd       <= w_wd_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_sending  <= (w_state_nxt != S_IDLE);
      r_timeout  <= w_timeout_nxt;
      r_overflow <= w_overflow_nxt;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; its contents are meaningless after rst_n anyway.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.sending  = r_sending;
  assign bus.timeout  = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_feeder                                             |
// | Purpose  : Self-checking bench for uart_tx_feeder: queue/timing model,   |
// |            stub transmitter, directed scenarios with literal checks.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_tx_feeder;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_feeder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: byte queue + frame timing -------------
  logic [7:0] mq[$];
  logic       e_start, e_send, e_to, e_ovf;
  logic [7:0] e_data;
  int         m_age;      // cycles since the tx_start cycle of the byte in flight
  logic       m_prev_send;
  int         m_prev_age;
  logic       m_pop;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      e_start = 0; e_send = 0; e_to = 0; e_ovf = 0; e_data = 8'h00; m_age = 0;
    end else begin
      m_prev_send = e_send;
      m_prev_age  = m_age;
      e_start = 0; e_to = 0; e_ovf = 0;
      m_pop = !m_prev_send && bus.enable && (mq.size() > 0);
      if (m_pop) begin
        e_data  = mq.pop_front();
        e_start = 1;
        e_send  = 1;
        m_age   = 0;
      end else if (m_prev_send) begin
        if (m_prev_age >= 1 && bus.tx_done) begin
          e_send = 0;
        end else if (m_prev_age == TIMEOUT) begin
          e_to   = 1;
          e_send = 0;
        end else begin
          m_age = m_prev_age + 1;
        end
      end
      if (bus.wr_en) begin
        if (mq.size() < DEPTH) mq.push_back(bus.wr_data);
        else                   e_ovf = 1;
      end
    end
  end

  // ---------------- per-cycle comparison ------------------------------------
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("tx_start", bus.tx_start, e_start);
      chk("tx_data",  bus.tx_data,  e_data);
      chk("sending",  bus.sending,  e_send);
      chk("timeout",  bus.timeout,  e_to);
      chk("overflow", bus.overflow, e_ovf);
      chk("count",    bus.count,    mq.size());
      chk("full",     bus.full,     mq.size() == DEPTH);
      chk("empty",    bus.empty,    mq.size() == 0);
    end
  end

  // ---------------- stub transmitter ----------------------------------------
  logic       hang    = 1'b0;
  logic       gap_chk = 1'b0;
  int         last_done_cyc = -1;
  logic [7:0] sent[$];
  logic [8:0] frame;
  logic       s_busy;
  int         s_cnt;
  logic [7:0] s_byte;

  initial begin
    bus.tx_done = 1'b0;
    bus.tx_busy = 1'b0;
    s_busy = 1'b0;
    s_cnt  = 0;
    s_byte = 8'h00;
    frame  = '0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (!rst_n) begin
        s_busy = 1'b0; bus.tx_busy = 1'b0;
      end else if (bus.timeout) begin
        s_busy = 1'b0; bus.tx_busy = 1'b0;
      end else if (bus.tx_start && !s_busy) begin
        if (gap_chk && last_done_cyc >= 0) chk("b2b_gap", cyc - last_done_cyc, 2);
        s_busy = 1'b1; bus.tx_busy = 1'b1; s_cnt = 0;
        s_byte = bus.tx_data;
        sent.push_back(bus.tx_data);
        frame[0] = 1'b0;
      end else if (s_busy) begin
        s_cnt++;
        if (s_cnt <= 8) frame[s_cnt] = s_byte[s_cnt-1];
        if (s_cnt == 11 && !hang) begin
          bus.tx_done = 1'b1; s_busy = 1'b0; bus.tx_busy = 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  logic [7:0] bq[$];
  logic [7:0] xq[$];
  int n;
  int t0;

  task automatic push_bytes();
    foreach (bq[i]) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = bq[i];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while (!(bus.empty && !bus.sending && !bus.tx_start) && k < max) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(bus.empty && !bus.sending && !bus.tx_start)) begin
      errors++;
      $display("FAIL %s: queue not drained within %0d cycles, count=%0d", name, max, bus.count);
    end
  endtask

  task automatic check_sent(input string name);
    logic ok;
    ok = (sent.size() == xq.size());
    if (ok) foreach (xq[i]) if (sent[i] !== xq[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d bytes (first %0h last %0h) expected %0d bytes (first %0h last %0h)",
               name, sent.size(), (sent.size() > 0) ? sent[0] : 8'hxx,
               (sent.size() > 0) ? sent[sent.size()-1] : 8'hxx,
               xq.size(), xq[0], xq[xq.size()-1]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"},    bus.count,    0);
    chk({tag, "_empty"},    bus.empty,    1);
    chk({tag, "_full"},     bus.full,     0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"},  bus.tx_data,  8'h00);
    chk({tag, "_sending"},  bus.sending,  0);
    chk({tag, "_timeout"},  bus.timeout,  0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- directed scenarios --------------------------------------
  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.enable = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // 1: single byte, line frame and idle afterwards
    bus.enable = 1'b1;
    sent.delete();
    bq = {8'h68};
    push_bytes();
    wait_drain("t1_drain", 60);
    xq = {8'h68};
    check_sent("t1_order");
    chk("t1_frame", frame, 9'b011010000);
    chk("t1_empty", bus.empty, 1);
    chk("t1_sending", bus.sending, 0);

    // 2: back-to-back frames, tx_start two cycles after each done
    sent.delete();
    gap_chk = 1'b1; last_done_cyc = -1;
    bq = {8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    push_bytes();
    wait_drain("t2_drain", 200);
    gap_chk = 1'b0;
    xq = {8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    check_sent("t2_order");

    // 3: fill to full with enable low, 17th byte overflows
    @(negedge clk); bus.enable = 1'b0;
    sent.delete();
    bq.delete();
    for (int i = 0; i < 17; i++) bq.push_back(8'hA0 + 8'(i));
    push_bytes();
    chk("t3_overflow", bus.overflow, 1);
    chk("t3_full", bus.full, 1);
    chk("t3_count", bus.count, 16);
    bus.enable = 1'b1;
    wait_drain("t3_drain", 400);
    xq.delete();
    for (int i = 0; i < 16; i++) xq.push_back(8'hA0 + 8'(i));
    check_sent("t3_order");

    // 4: transmitter never signals done -> watchdog abort
    @(negedge clk); bus.enable = 1'b0;
    hang = 1'b1;
    sent.delete();
    bq = {8'h11, 8'h22};
    push_bytes();
    bus.enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tx_start && n < 10);
    t0 = cyc;
    chk("t4_launch", bus.tx_start, 1);
    chk("t4_count_after_launch", bus.count, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.timeout && n < 40);
    chk("t4_timeout_seen", bus.timeout, 1);
    chk("t4_timeout_latency", cyc - t0, TIMEOUT + 1);
    chk("t4_count_at_timeout", bus.count, 1);
    hang = 1'b0;
    wait_drain("t4_drain", 60);
    xq = {8'h11, 8'h22};
    check_sent("t4_order");

    // 5: push at full in the same cycle as a pop, across pointer wrap
    @(negedge clk); bus.enable = 1'b0;
    sent.delete();
    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'hC0 + 8'(i));
    push_bytes();
    chk("t5_full", bus.full, 1);
    bus.enable = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hD0;
    @(negedge clk); bus.wr_en = 1'b0;
    chk("t5_no_overflow", bus.overflow, 0);
    chk("t5_count", bus.count, 16);
    chk("t5_launched", bus.tx_start, 1);
    wait_drain("t5_drain", 500);
    xq.delete();
    for (int i = 0; i < 17; i++) xq.push_back(8'hC0 + 8'(i));
    check_sent("t5_order");

    // 6: asynchronous reset mid-frame
    @(negedge clk); bus.enable = 1'b0;
    sent.delete();
    bq = {8'hE0, 8'hE1, 8'hE2, 8'hE3};
    push_bytes();
    bus.enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_sending", bus.sending, 1);
    chk("t6_count", bus.count, 3);
    #3 rst_n = 1'b0;
    #1 chk_reset("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_no_restart", sent.size(), 1);
    chk("t6_idle", bus.sending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
